dcache_ctrl: RTL

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through data cache controller
//
// Purpose: one-word-per-line direct-mapped data cache between a pipelined
// CPU MEM stage and a single-port backing memory. Load hits complete with
// zero stall. Load misses fill the line. Stores are write-through with no
// write-allocate.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   cpu_req_i         MEM-stage access valid
//   cpu_we_i          1 = store, 0 = load
//   cpu_addr_i        byte address (bits [1:0] ignored)
//   cpu_wdata_i       store data
//   cpu_rdata_o       load data (hit data in IDLE, response register in RESP)
//   cpu_stall_o       freezes the pipeline while high
//   mem_req_o         backing-memory request, held until mem_ack_i
//   mem_we_o          backing-memory write
//   mem_addr_o        word-aligned backing-memory address
//   mem_wdata_o       backing-memory write data (0 unless writing)
//   mem_rdata_i       backing-memory read data, valid with mem_ack_i
//   mem_ack_i         one-cycle completion pulse
module dcache_ctrl #(
    parameter int LINES = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    // addr_q holds the word-aligned address; its low two bits are always 0.
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] resp_q;

    logic [IDX_W-1:0] cpu_idx;
    logic [TAG_W-1:0] cpu_tag;
    logic [IDX_W-1:0] lat_idx;
    logic [TAG_W-1:0] lat_tag;
    logic             cpu_hit;
    logic             lat_hit;

    logic        latch_en;
    logic        stall_raw;
    logic        req_raw;
    logic [31:0] rdata_d;

    assign cpu_idx = cpu_addr_i[IDX_W+1:2];
    assign cpu_tag = cpu_addr_i[31:IDX_W+2];
    assign lat_idx = addr_q[IDX_W+1:2];
    assign lat_tag = addr_q[31:IDX_W+2];
    assign cpu_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        stall_raw = 1'b0;
        req_raw   = 1'b0;
        rdata_d   = 32'd0;
        latch_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    if (!cpu_we_i && cpu_hit) begin
                        rdata_d = data_q[cpu_idx];
                    end else begin
                        stall_raw = 1'b1;
                        latch_en  = 1'b1;
                        state_d   = cpu_we_i ? WR_THRU : RD_MISS;
                    end
                end
            end
            RD_MISS, WR_THRU: begin
                stall_raw = 1'b1;
                req_raw   = 1'b1;
                if (mem_ack_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rdata_d = resp_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset overrides the handshake outputs immediately so a frozen pipeline
    // is released and the memory sees the request drop in the same cycle.
    assign cpu_stall_o = stall_raw && !rst_i;
    assign mem_req_o   = req_raw && !rst_i;
    assign mem_we_o    = (state_q == WR_THRU) && !rst_i;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = (state_q == WR_THRU) ? wdata_q : 32'd0;
    assign cpu_rdata_o = rdata_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            resp_q  <= 32'd0;
        end else begin
            if (latch_en) begin
                addr_q  <= cpu_addr_i & 32'hFFFF_FFFC;
                wdata_q <= cpu_we_i ? cpu_wdata_i : 32'd0;
            end
            if (state_q == RD_MISS && mem_ack_i) begin
                valid_q[lat_idx] <= 1'b1;
                resp_q           <= mem_rdata_i;
            end
            if (state_q == WR_THRU && mem_ack_i) begin
                resp_q <= 32'd0;
            end
        end
    end

    // Tag/data arrays need no reset: valid_q gates every use of them.
    always_ff @(posedge clk_i) begin
        if (!rst_i && mem_ack_i) begin
            if (state_q == RD_MISS) begin
                tag_q[lat_idx]  <= lat_tag;
                data_q[lat_idx] <= mem_rdata_i;
            end else if (state_q == WR_THRU && lat_hit) begin
                data_q[lat_idx] <= wdata_q;
            end
        end
    end

endmodule
